// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined MIPS core.
// Owns the PC, picks the next PC from the resolving stage's decision,
// drives the instruction-memory read and fills the IF/ID register.
// Optional feature macro: FETCH_PERF_CNT_EN (fetch/stall perf counters).

package fetch_pkg;
  typedef enum logic [1:0] {
    ADD4_DIAOSI   = 2'd0,
    BRANCH_DIAOSI = 2'd1,
    JUMP_DIAOSI   = 2'd2,
    JR_DIAOSI     = 2'd3
  } PCSrc_t;

  typedef enum logic {
    BEQ_DIAOSI = 1'b0,
    BNE_DIAOSI = 1'b1
  } ZERO_SEL_t;
endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  PCSrc_t      pcsrc,
  input  ZERO_SEL_t   zero_sel,
  input  logic        zero,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        halt,
  input  logic        stall,
  input  logic        flush,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_npc_q;
  logic        ifid_valid_q;

  logic [31:0] pcPlus4;
  logic        branchTaken;
  logic        redirect;
  logic [31:0] redirectTarget;

  assign pcPlus4 = pc_q + 32'd4;

  // Resolve whether this edge redirects the PC, and to where
  always_comb begin
    branchTaken    = 1'b0;
    redirect       = 1'b0;
    redirectTarget = pcPlus4;
    unique case (pcsrc)
      JUMP_DIAOSI: begin
        redirect       = 1'b1;
        redirectTarget = {pcPlus4[31:28], jump_index, 2'b00};
      end
      JR_DIAOSI: begin
        redirect       = 1'b1;
        redirectTarget = jr_target;
      end
      BRANCH_DIAOSI: begin
        branchTaken    = (zero_sel == BEQ_DIAOSI) ? zero : !zero;
        redirect       = branchTaken;
        redirectTarget = branch_target;
      end
      default: begin
        redirect       = 1'b0;
        redirectTarget = pcPlus4;
      end
    endcase
  end

  // Run/halt FSM together with the PC and IF/ID register, in priority order
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= RUN;
      pc_q         <= PC_INIT;
      ifid_instr_q <= 32'd0;
      ifid_npc_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (halt) begin
        state_q      <= HALTED;
        ifid_instr_q <= 32'd0;
        ifid_npc_q   <= 32'd0;
        ifid_valid_q <= 1'b0;
      end else if (redirect) begin
        pc_q         <= redirectTarget;
        ifid_instr_q <= 32'd0;
        ifid_npc_q   <= 32'd0;
        ifid_valid_q <= 1'b0;
      end else if (flush) begin
        ifid_instr_q <= 32'd0;
        ifid_npc_q   <= 32'd0;
        ifid_valid_q <= 1'b0;
        if (ihit && !stall) begin
          pc_q <= pcPlus4;
        end
      end else if (!stall && ihit) begin
        ifid_instr_q <= iload;
        ifid_npc_q   <= pcPlus4;
        ifid_valid_q <= 1'b1;
        pc_q         <= pcPlus4;
      end
    end
  end

  assign iREN       = (state_q == RUN);
  assign iaddr      = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_npc   = ifid_npc_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCnt_q;
  logic [31:0] stallCnt_q;
  logic        fetchEvent;
  logic        stallEvent;

  assign fetchEvent = (state_q == RUN) && !halt && !redirect && !flush && !stall && ihit;
  assign stallEvent = (state_q == RUN) && stall && !redirect;

  // Performance counters: wrap naturally, frozen while halted
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fetchCnt_q <= 32'd0;
      stallCnt_q <= 32'd0;
    end else begin
      if (fetchEvent) begin
        fetchCnt_q <= fetchCnt_q + 32'd1;
      end
      if (stallEvent) begin
        stallCnt_q <= stallCnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetchCnt_q;
  assign stall_cnt = stallCnt_q;
`else
  assign fetch_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter and selects the next PC from the `PCSrc_t` decision and the branch condition (`ZERO_SEL_t` plus ALU zero). It drives the instruction-memory read request and captures returned instructions into the IF/ID pipeline register, with stall, flush and halt control. The output feeds decode, which produces the `PCSrc_t`/`W_mux_t`/`ALUSrc_t`/`ExtOP_t` controls.

## Interface
Parameters:
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `CLK` in 1: the single clock; all state updates on its rising edge.
- `nRST` in 1: synchronous, active-low reset, sampled on the rising edge of `CLK`.
- `pcsrc` in `PCSrc_t` (2): next-PC select from the resolving stage.
- `zero_sel` in `ZERO_SEL_t` (1): branch sense.
- `zero` in 1: ALU zero flag for the branch.
- `branch_target` in 32: precomputed branch address.
- `jump_index` in 26: J-type target field.
- `jr_target` in 32: register value for JR.
- `halt` in 1: halt request from the resolving stage.
- `stall` in 1: hazard-unit hold of PC and IF/ID.
- `flush` in 1: squash IF/ID contents.
- `ihit` in 1: instruction memory returns `iload` this cycle.
- `iload` in 32: instruction data.
- `iREN` out 1: instruction read enable.
- `iaddr` out 32: instruction address, equal to the current `pc`.
- `ifid_instr` out 32: latched instruction.
- `ifid_npc` out 32: PC+4 of the latched instruction.
- `ifid_valid` out 1: IF/ID holds a live instruction.
- `halted` out 1: core halted.
- `fetch_cnt` out 32: perf counter (see Configuration).
- `stall_cnt` out 32: perf counter (see Configuration).

## Operation
- FSM states are RUN and HALTED. Reset enters RUN. RUN goes to HALTED when `halt`=1. HALTED is left only by reset.
- In RUN, `iREN`=1 and `iaddr`=`pc`. In HALTED, `iREN`=0, `pc` and IF/ID are frozen, and `halted`=1.
- Branch taken: `pcsrc`==BRANCH_DIAOSI and (`zero_sel`==BEQ_DIAOSI ? `zero` : !`zero`).
- Redirect target selection:
  - JUMP_DIAOSI: {`pc_plus4`[31:28], `jump_index`, 2'b00}.
  - JR_DIAOSI: `jr_target`.
  - BRANCH_DIAOSI taken: `branch_target`.
  - BRANCH_DIAOSI not taken: no redirect.
  - ADD4_DIAOSI: no redirect.
- `pc_plus4` is `pc`+32'd4 with modulo-2^32 wrap (32'hFFFF_FFFC wraps to 0).
- Per-edge priority, highest first:
  1. `nRST`=0: `pc`=`PC_INIT`, IF/ID cleared, state RUN.
  2. `halt`: enter HALTED; IF/ID cleared.
  3. Redirect: `pc`=target; IF/ID cleared (`ifid_valid`=0, `ifid_instr`=0); any concurrent `ihit` data is dropped.
  4. `flush` (without redirect): IF/ID cleared; `pc` advances only if `ihit` and not `stall`.
  5. `stall`: `pc` and IF/ID hold; a concurrent `ihit` is ignored and the same address is refetched later.
  6. `ihit`: `ifid_instr`=`iload`, `ifid_npc`=`pc_plus4`, `ifid_valid`=1, `pc`=`pc_plus4`.
  7. Otherwise: hold, and wait for `ihit`.
- Redirect overrides `stall`.
- Low-order PC bits are not checked. A misaligned target is fetched as given.
- Reset values: `pc`=`PC_INIT`, `ifid_instr`=0, `ifid_npc`=0, `ifid_valid`=0, `halted`=0, counters 0. `iREN` is 1 from the first cycle after reset release.

## Timing
- Fetch latency is set by memory. The IF/ID update occurs on the edge that samples `ihit`=1, so with single-cycle `ihit` throughput is one instruction per cycle.
- `iaddr`/`iREN` are combinational from registered state. No combinational path from `iload` to any output.
- Redirect, flush and halt take effect on the edge at which they are sampled. The next cycle's `iaddr` is the target.
- Reset asserted mid-fetch discards the outstanding request. Memory must tolerate `iaddr` changing without `ihit`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_cnt` increments on every edge that loads IF/ID from `ihit`.
  - `stall_cnt` increments on every RUN-state edge with `stall`=1 and no redirect.
  - Both counters are 32-bit, wrap at 2^32, clear on reset, and freeze in HALTED.
- `FETCH_PERF_CNT_EN` not defined: both outputs are constant 0 and no counter flops are built.

## Test plan
- Reset with `PC_INIT`=32'h0000_0040 → `iaddr`=0x40, `iREN`=1, `ifid_valid`=0. Then `ihit` with `iload`=0x2001_0005 → `ifid_instr`=0x2001_0005, `ifid_npc`=0x44, `iaddr`=0x44.
- `pcsrc`=BRANCH, `zero_sel`=BEQ, `zero`=1, `branch_target`=0x100, with `ihit`=1 the same cycle → `iaddr`=0x100 and `ifid_valid`=0. Repeat with `zero`=0 → `pc`=`pc_plus4` and the instruction is latched. Repeat with `zero_sel`=BNE, `zero`=0 → branch taken.
- `pc`=0x1000_0010, JUMP, `jump_index`=26'h0000_040 → `iaddr`=0x1000_0100. JR with `jr_target`=0xABC0 → `iaddr`=0xABC0.
- `stall`=1 for 3 cycles while `ihit`=1 → `pc` and IF/ID are unchanged. `stall_cnt`=3 with the macro, 0 without it.
- `stall`=1 and JR in the same cycle → redirect taken and IF/ID cleared. `flush` alone with `ihit` → `ifid_valid`=0 and `pc` advances by 4.
- `halt` pulse → `halted`=1, `iREN`=0, and `pc` frozen for 10 cycles despite `ihit`. `nRST`=0 for one edge → back to `PC_INIT` in RUN.
